// File: rtl/dmem_responder.sv
// Fixed-latency word data-memory responder for the core's load/store port.
// Define DMEM_BACK2BACK_EN to accept a new request in the response-handshake cycle.
module dmem_responder #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          lat_write;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;

    logic [7:0]    mem [MEM_BYTES];

    logic          req_fire;
    logic          rsp_fire;
    logic          access;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   load_word;

`ifdef DMEM_BACK2BACK_EN
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
    assign req_ready = (state == IDLE);
`endif

    assign rsp_valid = (state == RESP);
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign access    = (state == WAIT) && (count == '0);

    // Range check is on the full 32-bit address so high addresses never alias.
    assign acc_err   = (lat_addr[1:0] != 2'b00) || (lat_addr > 32'(MEM_BYTES - 4));
    assign acc_idx   = lat_addr[AW-1:0];
    assign load_word = {mem[acc_idx + AW'(3)], mem[acc_idx + AW'(2)],
                        mem[acc_idx + AW'(1)], mem[acc_idx]};

    // Control FSM, request latch and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        count     <= CW'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_write) ? 32'h0 : load_word;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
`ifdef DMEM_BACK2BACK_EN
                        if (req_fire) begin
                            lat_write <= req_write;
                            lat_addr  <= req_addr;
                            lat_wdata <= req_wdata;
                            lat_be    <= req_be;
                            count     <= CW'(LATENCY - 1);
                            state     <= WAIT;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is not reset; stores commit on the same edge the response is formed.
    always_ff @(posedge clk) begin
        if (access && lat_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[acc_idx + AW'(i)] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MIPS core's load/store port; services the core's word requests over a valid/ready request channel and a valid/ready response channel.
- Byte-addressable little-endian storage, same layout as the core's internal d_mem: byte addr+0 maps to data[7:0] and byte addr+3 maps to data[31:24].
- Fixed, parameterised access latency through a small FSM. This is the target for moving the core off its single-cycle internal memory.

Parameters:
- MEM_BYTES, 128, storage size in bytes; multiple of 4.
- LATENCY, 2, cycles from request accept edge to rsp_valid rising; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1=store (sw), 0=load (lw)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i covers byte addr+i; ignored on loads
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or out of range

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not reset. A pending or in-flight request is dropped and its store is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch write, addr, wdata and be; counter<=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - If counter!=0, counter decrements.
  - If counter==0: perform the access at this edge and go to RESP.
- Latency: request accepted at edge E0, so rsp_valid is high from edge E(LATENCY). Example: LATENCY=1 accepts at E0 and responds after E1.
- Access performed at the WAIT→RESP edge:
  - err = (addr[1:0]!=0) || (addr > MEM_BYTES-4), computed with unsigned 32-bit compare, no wrap.
  - If err: no memory change, rsp_rdata<=0, rsp_err<=1.
  - Load: rsp_rdata<={mem[a+3],mem[a+2],mem[a+1],mem[a]}.
  - Store: mem[a+i]<=wdata[8i+7:8i] for each be[i]=1. rsp_rdata<=0. A store with be=0000 is legal and changes nothing.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake: go to IDLE, rsp_valid drops next cycle, rsp_rdata and rsp_err are cleared to 0.
  - req_ready=0 in RESP unless the optional feature is enabled.
- Request inputs are only sampled at the accept edge; changes while in WAIT or RESP have no effect.
- A load issued after a store returns the stored value, because stores commit before their response.
- rsp_ready asserted with no response pending is ignored.

Optional Feature:
- Macro: DMEM_BACK2BACK_EN.
- Defined:
  - In RESP, req_ready=rsp_ready.
  - If the response handshake and a request handshake happen in the same cycle, the new request is latched, counter<=LATENCY-1, and the FSM goes directly to WAIT. rsp_valid drops for at least one cycle.
  - Sustained throughput is one access per LATENCY+1 cycles.
- Undefined:
  - req_ready=0 in RESP; the FSM always passes through IDLE.
  - Throughput is one access per LATENCY+2 cycles.

Test Plan:
- Reset then store, LATENCY=2: sw addr=0x10, wdata=0xDEADBEEF, be=1111 → rsp_valid rises 2 cycles after accept with rsp_err=0 and rsp_rdata=0. A following lw 0x10 returns 0xDEADBEEF, and byte 0x10 holds 0xEF.
- Byte enables: after the test above, sw 0x10 wdata=0x11223344 be=0101 → lw 0x10 returns 0xDE22BE44.
- Errors: lw 0x12 → rsp_err=1, rdata=0. sw 0x7C is legal. sw 0x80 → rsp_err=1 and memory is unchanged. lw 0xFFFFFFFC → rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_valid and rdata stay stable and req_ready=0 throughout. Then pulse rsp_ready → FSM returns to IDLE and req_ready=1.
- Reset mid-operation: sw 0x20 wdata=0xCAFEF00D accepted, then rst_n low in WAIT → outputs return to reset values immediately, and a later lw 0x20 does not return 0xCAFEF00D.
- DMEM_BACK2BACK_EN, LATENCY=1, req_valid and rsp_ready held high with 4 loads → 4 responses in 8 cycles, rsp_valid toggles 1,0 each response. Without the macro → 4 responses in 12 cycles.
